uart_start_detect: RTL and testbench

//  Parametrised UART receive start-bit detector; successor to the plain rx_in==0 comparator.

---
 rtl/uart_start_detect.sv | 216 +++++++++++++++++++++
 tb/tb_uart_start_detect.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_start_detect.sv
// ---------------------------------------------------------------------------
// uart_start_detect
//
// UART receive start-bit detector. It sits between the baud oversample tick
// generator and the receive shift FSM.
//
// The asynchronous rx_in line passes through a SYNC_STAGES flop synchroniser.
// The synchronised line is evaluated only on sample_tick. A start bit is
// confirmed when the line falls, after being seen high, and then stays low for
// MID_COUNT consecutive ticks. That point is the centre of the start bit.
//
// A low run that ends before MID_COUNT ticks reports a false start. After a
// confirmed start the detector locks out until two things hold at a tick:
// the receiver has dropped rx_busy, and the line is back high.
//
// Output pulse semantics:
//   start_bit_detected and false_start are registered one-clock strobes.
//   Each is raised on the clock after the tick that decided it.
//   The two strobes are never high in the same clock.
//   There is no backpressure: the consumer must take the strobe in that clock.
//
// Optional build macro: UART_START_GLITCH_FILTER_EN
//   When defined, a 3-deep tick history of the synchronised line feeds a
//   majority vote. This removes single-tick glitches and adds 2 ticks of
//   detection latency.
//   When undefined, the synchronised line is used directly.
//
// det_state encoding: 0 = IDLE, 1 = CHECK, 2 = LOCK.
// ---------------------------------------------------------------------------
module uart_start_detect #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MID_COUNT   = OVERSAMPLE / 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       sample_tick,
    input  logic       rx_in,
    input  logic       rx_busy,
    output logic       start_bit_detected,
    output logic       false_start,
    output logic [1:0] det_state
);

    // Counter is wide enough to hold OVERSAMPLE. It never exceeds MID_COUNT.
    localparam int CW = $clog2(OVERSAMPLE + 1);

    localparam logic [CW-1:0] MID_C = CW'(MID_COUNT);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_LOCK  = 2'd2;

    // -----------------------------------------------------------------------
    // Synchroniser.
    // Resets to all ones so the line reads as idle (high) out of reset.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   rx_s;

    // Shift rx_in into the chain every clock; the last stage is the usable line.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx_in};
    end

    // Synchroniser flops, reset to the idle-high level.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Sampled line value seen by the FSM.
    // -----------------------------------------------------------------------
    logic rx_v;

`ifdef UART_START_GLITCH_FILTER_EN
    // History holds the three most recent tick samples, newest in bit 0.
    logic [2:0] hist_q;
    logic [2:0] hist_d;

    // Capture the synchronised line into the history on every tick.
    always_comb begin
        hist_d = hist_q;
        if (sample_tick) begin
            hist_d = {hist_q[1:0], rx_s};
        end
    end

    // History flops. Reset to idle-high so no phantom edge appears after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist_q <= 3'b111;
        end else begin
            hist_q <= hist_d;
        end
    end

    // A two-of-three vote hides any single-tick excursion of the line.
    assign rx_v = (hist_q[0] & hist_q[1]) |
                  (hist_q[0] & hist_q[2]) |
                  (hist_q[1] & hist_q[2]);
`else
    assign rx_v = rx_s;
`endif

    // -----------------------------------------------------------------------
    // Detector FSM.
    // -----------------------------------------------------------------------
    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          prev_q;
    logic          prev_d;
    logic          det_q;
    logic          det_d;
    logic          fs_q;
    logic          fs_d;

    // In CHECK, cnt_q is below MID_COUNT, so the increment cannot wrap.
    assign cnt_inc = cnt_q + ONE_C;

    // Next-state logic. Nothing moves without a tick. A low enable parks the
    // detector in IDLE and quietly abandons any partial start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        det_d   = 1'b0;
        fs_d    = 1'b0;

        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            prev_d  = 1'b1;
        end else if (sample_tick) begin
            prev_d = rx_v;
            case (state_q)
                S_IDLE: begin
                    // Arm only on a true falling edge: high at the last tick, low now.
                    if (prev_q && !rx_v) begin
                        if (MID_C == ONE_C) begin
                            state_d = S_LOCK;
                            cnt_d   = MID_C;
                            det_d   = 1'b1;
                        end else begin
                            state_d = S_CHECK;
                            cnt_d   = ONE_C;
                        end
                    end
                end
                S_CHECK: begin
                    if (!rx_v) begin
                        if (cnt_inc >= MID_C) begin
                            state_d = S_LOCK;
                            cnt_d   = MID_C;
                            det_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // The line went back high before mid-bit, so this was a glitch.
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        fs_d    = 1'b1;
                    end
                end
                S_LOCK: begin
                    // Release only once the receiver is done and the line is idle.
                    if (!rx_busy && rx_v) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        prev_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    prev_d  = 1'b1;
                end
            endcase
        end
    end

    // FSM and pulse registers. Reset clears everything, including any pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prev_q  <= 1'b1;
            det_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            det_q   <= det_d;
            fs_q    <= fs_d;
        end
    end

    assign start_bit_detected = det_q;
    assign false_start        = fs_q;
    assign det_state          = state_q;

endmodule

// File: tb/tb_uart_start_detect.sv
// ---------------------------------------------------------------------------
// tb_uart_start_detect
//
// Bench for uart_start_detect at the default parameters
// (OVERSAMPLE=16, SYNC_STAGES=2, MID_COUNT=8).
//
// The reference model works in terms of the line itself:
//   - a delay line gives the synchronised value;
//   - an optional 3-sample vote gives the filtered value;
//   - a low-run length and a locked flag give the detector status.
//
// Build with +define+UART_START_GLITCH_FILTER_EN to exercise the filter.
// ---------------------------------------------------------------------------
module tb_uart_start_detect;

  localparam int OVERSAMPLE  = 16;
  localparam int SYNC_STAGES = 2;
  localparam int MID_COUNT   = 8;
`ifdef UART_START_GLITCH_FILTER_EN
  localparam int FILT_LAT = 2;
`else
  localparam int FILT_LAT = 0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       sample_tick;
  logic       rx_in;
  logic       rx_busy;
  logic       start_bit_detected;
  logic       false_start;
  logic [1:0] det_state;

  always #5 clock = ~clock;

  uart_start_detect #(
    .OVERSAMPLE (OVERSAMPLE),
    .SYNC_STAGES(SYNC_STAGES),
    .MID_COUNT  (MID_COUNT)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .sample_tick       (sample_tick),
    .rx_in             (rx_in),
    .rx_busy           (rx_busy),
    .start_bit_detected(start_bit_detected),
    .false_start       (false_start),
    .det_state         (det_state)
  );

  // Reference model state.
  logic       line_q[$];   // rx_in values still travelling through the synchroniser
  logic [2:0] hist_m;      // last three tick samples of the synchronised line
  bit         m_locked;    // a start was confirmed and not yet released
  int         m_run;       // length of the current armed low run (0 = not armed)
  logic       m_prev;      // line value at the previous tick
  logic       exp_det;
  logic       exp_fs;
  logic [1:0] exp_state;

  int n_err = 0;
  int n_chk = 0;

  task automatic model_reset();
    line_q.delete();
    for (int i = 0; i < SYNC_STAGES; i++) line_q.push_back(1'b1);
    hist_m    = 3'b111;
    m_locked  = 0;
    m_run     = 0;
    m_prev    = 1'b1;
    exp_det   = 1'b0;
    exp_fs    = 1'b0;
    exp_state = 2'd0;
  endtask

  // Drive one clock of stimulus, advance the model across the edge,
  // and return at the following negedge, ready for sampling.
  task automatic step(input logic rx, input logic tk, input logic en,
                      input logic busy, input logic rst);
    logic rxs;
    logic v;
    reset       = rst;
    enable      = en;
    sample_tick = tk;
    rx_in       = rx;
    rx_busy     = busy;
    @(posedge clock);
    rxs = line_q[0];
`ifdef UART_START_GLITCH_FILTER_EN
    v = (hist_m[0] + hist_m[1] + hist_m[2]) >= 2;
`else
    v = rxs;
`endif
    exp_det = 1'b0;
    exp_fs  = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      void'(line_q.pop_front());
      line_q.push_back(rx);
      if (tk) hist_m = {hist_m[1:0], rxs};
      if (!en) begin
        m_locked = 0;
        m_run    = 0;
        m_prev   = 1'b1;
      end else if (tk) begin
        if (m_locked) begin
          if (!busy && v) m_locked = 0;
        end else if (m_run > 0) begin
          if (!v) begin
            m_run++;
            if (m_run >= MID_COUNT) begin
              m_locked = 1;
              m_run    = 0;
              exp_det  = 1'b1;
            end
          end else begin
            m_run  = 0;
            exp_fs = 1'b1;
          end
        end else if (m_prev && !v) begin
          m_run = 1;
          if (m_run >= MID_COUNT) begin
            m_locked = 1;
            m_run    = 0;
            exp_det  = 1'b1;
          end
        end
        m_prev = v;
      end
    end
    exp_state = m_locked ? 2'd2 : ((m_run > 0) ? 2'd1 : 2'd0);
    @(negedge clock);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      n_chk++;
      if ({start_bit_detected, false_start, det_state} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_hold: got det=%b fs=%b st=%0d want det=0 fs=0 st=0",
                 start_bit_detected, false_start, det_state);
      end
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    // Go low long enough to be well into CHECK, but short of mid-bit.
    for (int i = 0; i < SYNC_STAGES + FILT_LAT + 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      n_chk++;
      if ({start_bit_detected, false_start, det_state} !== {exp_det, exp_fs, exp_state}) begin
        n_err++;
        $display("FAIL reset_pre: got det=%b fs=%b st=%0d want det=%b fs=%b st=%0d",
                 start_bit_detected, false_start, det_state, exp_det, exp_fs, exp_state);
      end
    end
    n_chk++;
    if (det_state !== 2'd1) begin
      n_err++;
      $display("FAIL reset_in_check: got st=%0d want st=1", det_state);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    n_chk++;
    if ({start_bit_detected, false_start, det_state} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_mid_check: got det=%b fs=%b st=%0d want det=0 fs=0 st=0",
               start_bit_detected, false_start, det_state);
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_valid_start();
    int det_cnt = 0;
    int det_at  = -1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16 + FILT_LAT; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      if (start_bit_detected === 1'b1) begin
        det_cnt++;
        det_at = i;
      end
      n_chk++;
      if ({start_bit_detected, false_start, det_state} !== {exp_det, exp_fs, exp_state}) begin
        n_err++;
        $display("FAIL valid_cyc%0d: got det=%b fs=%b st=%0d want det=%b fs=%b st=%0d", i,
                 start_bit_detected, false_start, det_state, exp_det, exp_fs, exp_state);
      end
    end
    n_chk++;
    if (det_cnt !== 1) begin
      n_err++;
      $display("FAIL valid_count: got %0d pulses want 1", det_cnt);
    end
    n_chk++;
    if (det_at !== SYNC_STAGES + MID_COUNT - 1 + FILT_LAT) begin
      n_err++;
      $display("FAIL valid_timing: pulse at clock %0d want %0d", det_at,
               SYNC_STAGES + MID_COUNT - 1 + FILT_LAT);
    end
    n_chk++;
    if (det_state !== 2'd2) begin
      n_err++;
      $display("FAIL valid_lock: got st=%0d want st=2", det_state);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_lockout();
    int pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
      pulses += int'(start_bit_detected) + int'(false_start);
      n_chk++;
      if ({start_bit_detected, false_start, det_state} !== {exp_det, exp_fs, exp_state}) begin
        n_err++;
        $display("FAIL lock_cyc%0d: got det=%b fs=%b st=%0d want det=%b fs=%b st=%0d", i,
                 start_bit_detected, false_start, det_state, exp_det, exp_fs, exp_state);
      end
    end
    n_chk++;
    if (pulses !== 0 || det_state !== 2'd2) begin
      n_err++;
      $display("FAIL lock_hold: got pulses=%0d st=%0d want pulses=0 st=2", pulses, det_state);
    end
    for (int i = 0; i < SYNC_STAGES + FILT_LAT + 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_chk++;
    if (det_state !== 2'd0) begin
      n_err++;
      $display("FAIL lock_release: got st=%0d want st=0", det_state);
    end
    pulses = 0;
    for (int i = 0; i < 16 + FILT_LAT; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      pulses += int'(start_bit_detected);
      n_chk++;
      if ({start_bit_detected, false_start, det_state} !== {exp_det, exp_fs, exp_state}) begin
        n_err++;
        $display("FAIL relock_cyc%0d: got det=%b fs=%b st=%0d want det=%b fs=%b st=%0d", i,
                 start_bit_detected, false_start, det_state, exp_det, exp_fs, exp_state);
      end
    end
    n_chk++;
    if (pulses !== 1) begin
      n_err++;
      $display("FAIL relock_count: got %0d pulses want 1", pulses);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_glitch();
    int dets = 0;
    int fss  = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3 + 8; i++) begin
      step((i < 3) ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      dets += int'(start_bit_detected);
      fss  += int'(false_start);
      n_chk++;
      if ({start_bit_detected, false_start, det_state} !== {exp_det, exp_fs, exp_state}) begin
        n_err++;
        $display("FAIL glitch_cyc%0d: got det=%b fs=%b st=%0d want det=%b fs=%b st=%0d", i,
                 start_bit_detected, false_start, det_state, exp_det, exp_fs, exp_state);
      end
    end
    n_chk++;
    if (dets !== 0 || fss !== 1 || det_state !== 2'd0) begin
      n_err++;
      $display("FAIL glitch_result: got det=%0d fs=%0d st=%0d want det=0 fs=1 st=0",
               dets, fss, det_state);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_tick_spacing();
    int det_at = -1;
    int fss    = 0;
    for (int i = 0; i < 24; i++) step(1'b1, (i % 4) == 0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 60; i++) begin
      step(1'b0, (i % 4) == 0, 1'b1, 1'b1, 1'b0);
      if (start_bit_detected === 1'b1 && det_at < 0) det_at = i;
      n_chk++;
      if ({start_bit_detected, false_start, det_state} !== {exp_det, exp_fs, exp_state}) begin
        n_err++;
        $display("FAIL spacing_cyc%0d: got det=%b fs=%b st=%0d want det=%b fs=%b st=%0d", i,
                 start_bit_detected, false_start, det_state, exp_det, exp_fs, exp_state);
      end
    end
    n_chk++;
    if (det_at < 28 || det_at > 44) begin
      n_err++;
      $display("FAIL spacing_timing: pulse at clock %0d want 28..44", det_at);
    end
    // Return to idle, then drop enable part-way through CHECK.
    for (int i = 0; i < 24; i++) step(1'b1, (i % 4) == 0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 16 + 4 * FILT_LAT; i++) step(1'b0, (i % 4) == 0, 1'b1, 1'b0, 1'b0);
    n_chk++;
    if (det_state !== 2'd1) begin
      n_err++;
      $display("FAIL spacing_in_check: got st=%0d want st=1", det_state);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      fss += int'(false_start) + int'(start_bit_detected);
    end
    n_chk++;
    if (fss !== 0 || det_state !== 2'd0) begin
      n_err++;
      $display("FAIL spacing_disable: got pulses=%0d st=%0d want pulses=0 st=0", fss, det_state);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_random();
    logic lvl  = 1'b1;
    int   left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (left == 0) begin
        lvl  = ~lvl;
        left = $urandom_range(1, 30);
      end
      left--;
      step(lvl, $urandom_range(0, 2) != 0, $urandom_range(0, 60) != 0,
           $urandom_range(0, 3) == 0, 1'b0);
      n_chk++;
      if ({start_bit_detected, false_start, det_state} !== {exp_det, exp_fs, exp_state}) begin
        n_err++;
        $display("FAIL random_cyc%0d: got det=%b fs=%b st=%0d want det=%b fs=%b st=%0d", i,
                 start_bit_detected, false_start, det_state, exp_det, exp_fs, exp_state);
      end
    end
  endtask

`ifdef UART_START_GLITCH_FILTER_EN
  // -------------------------------------------------------------------------
  task automatic test_filter_glitch();
    int bad = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step((i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      if (det_state !== 2'd0 || start_bit_detected !== 1'b0 || false_start !== 1'b0) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL filter_glitch: got %0d disturbed clocks want 0", bad);
    end
  endtask
`endif

  initial begin
    model_reset();
    reset       = 1'b1;
    enable      = 1'b1;
    sample_tick = 1'b0;
    rx_in       = 1'b1;
    rx_busy     = 1'b0;
    @(negedge clock);
    test_reset();
    test_valid_start();
    test_lockout();
    test_glitch();
    test_tick_spacing();
`ifdef UART_START_GLITCH_FILTER_EN
    test_filter_glitch();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
